// File: rtl/bootrom_loader_if.sv
// Download-port and CPU-bus signals shared by the boot ROM loader, its host and the upd7800.
// The master modport drives the download and address inputs. The slave modport returns ROM data and status.
interface bootrom_loader_if;
  logic        DL_ACTIVE;
  logic        DL_WR;
  logic [11:0] DL_ADDR;
  logic [7:0]  DL_DATA;
  logic [15:0] A;
  logic [7:0]  DB;
  logic        nCS;
  logic        CPU_RESETB;
  logic        LOADED;
  logic [7:0]  CKSUM;
  logic [12:0] BYTE_COUNT;

  modport master (
    output DL_ACTIVE, DL_WR, DL_ADDR, DL_DATA, A,
    input  DB, nCS, CPU_RESETB, LOADED, CKSUM, BYTE_COUNT
  );

  modport slave (
    input  DL_ACTIVE, DL_WR, DL_ADDR, DL_DATA, A,
    output DB, nCS, CPU_RESETB, LOADED, CKSUM, BYTE_COUNT
  );
endinterface

// File: rtl/bootrom_loader.sv
// 4 KiB boot ROM image loader: it accepts a host download and holds the CPU in reset until the image settles. It then serves reads.
// DB has one cycle of read latency. The download port has no backpressure, so every strobe in LOAD is accepted.
module bootrom_loader #(
  parameter int unsigned RELEASE_CYCLES = 16
) (
  input  logic            CLK,
  input  logic            RES,
  bootrom_loader_if.slave bus
);

  localparam logic [7:0]  SETTLE_LAST = 8'(RELEASE_CYCLES - 1);
  localparam logic [12:0] COUNT_MAX   = 13'd4096;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [7:0]  cksum_q, cksum_d;
  logic [12:0] count_q, count_d;
  logic        run_q, run_d;
  logic [7:0]  db_q, db_d;
  logic        wr_en;
  logic        ncs;

  logic [7:0]  mem_q [4096];

  assign ncs = |bus.A[15:12];

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    cksum_d      = cksum_q;
    count_d      = count_q;
    wr_en        = 1'b0;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (bus.DL_ACTIVE) begin
          state_d = S_LOAD;
          cksum_d = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        // A strobe that arrives in the same cycle as the window closing is dropped.
        if (!bus.DL_ACTIVE) begin
          state_d      = (count_q != '0) ? S_SETTLE : S_IDLE;
          settle_cnt_d = '0;
        end else if (bus.DL_WR) begin
          wr_en   = 1'b1;
          cksum_d = cksum_q + bus.DL_DATA;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + 13'd1;
          end
        end
      end
      S_SETTLE: begin
        if (bus.DL_ACTIVE) begin
          state_d = S_LOAD;
          cksum_d = '0;
          count_d = '0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = S_RUN;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Release is registered from the next state, so it rises on the same edge that enters RUN.
    run_d = (state_d == S_RUN);
    db_d  = (state_q == S_RUN && !ncs) ? mem_q[bus.A[11:0]] : 8'hFF;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      cksum_q      <= '0;
      count_q      <= '0;
      run_q        <= 1'b0;
      db_q         <= 8'hFF;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      cksum_q      <= cksum_d;
      count_q      <= count_d;
      run_q        <= run_d;
      db_q         <= db_d;
    end
  end

  // The image survives reset. Only a completed download releases the CPU.
  always_ff @(posedge CLK) begin
    if (wr_en && !RES) begin
      mem_q[bus.DL_ADDR] <= bus.DL_DATA;
    end
  end

  assign bus.DB         = db_q;
  assign bus.nCS        = ncs;
  assign bus.CPU_RESETB = run_q;
  assign bus.LOADED     = run_q;
  assign bus.CKSUM      = cksum_q;
  assign bus.BYTE_COUNT = count_q;

endmodule

// File: tb/tb_bootrom_loader.sv
// Self-checking bench for bootrom_loader.
// A byte-array image and running sum/count model supply the expected values for the randomised downloads and reads.
module tb_bootrom_loader;

  logic clk;
  logic res;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] ref_mem [4096];
  int         ref_sum = 0;
  int         ref_n   = 0;

  bootrom_loader_if bus ();

  bootrom_loader #(.RELEASE_CYCLES(16)) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_cksum();
    return 8'(ref_sum);
  endfunction

  function automatic logic [12:0] exp_count();
    return (ref_n > 4096) ? 13'd4096 : 13'(ref_n);
  endfunction

  function automatic logic [7:0] exp_db(input logic [15:0] a);
    if (a[15:12] != 4'h0) return 8'hFF;
    return ref_mem[a[11:0]];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl();
    bus.DL_ACTIVE = 1'b1;
    bus.DL_WR     = 1'b0;
    step();
    ref_sum = 0;
    ref_n   = 0;
  endtask

  task automatic wr_byte(input logic [11:0] a, input logic [7:0] d);
    bus.DL_WR   = 1'b1;
    bus.DL_ADDR = a;
    bus.DL_DATA = d;
    step();
    bus.DL_WR   = 1'b0;
    ref_mem[a]  = d;
    ref_sum     = ref_sum + int'(d);
    ref_n       = ref_n + 1;
  endtask

  // Closes the download window, optionally with a strobe that must be dropped, and reports the cycle of release.
  task automatic release_wait(input bit ghost, input logic [11:0] ga, input logic [7:0] gd, output int rise);
    bus.DL_ACTIVE = 1'b0;
    bus.DL_WR     = ghost;
    bus.DL_ADDR   = ga;
    bus.DL_DATA   = gd;
    rise = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      bus.DL_WR = 1'b0;
      if (bus.CPU_RESETB === 1'b1) begin
        rise = k;
        break;
      end
    end
  endtask

  task automatic read_db(input logic [15:0] a, output logic [7:0] d);
    bus.A = a;
    step();
    d = bus.DB;
  endtask

  task automatic test_reset();
    res = 1'b1;
    bus.DL_ACTIVE = 1'b0;
    bus.DL_WR = 1'b0;
    bus.DL_ADDR = '0;
    bus.DL_DATA = '0;
    bus.A = '0;
    repeat (3) step();
    n_checks++; if (bus.CPU_RESETB !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_resetb got %b want 0", bus.CPU_RESETB); end
    n_checks++; if (bus.LOADED !== 1'b0) begin n_fail++; $display("FAIL reset_loaded got %b want 0", bus.LOADED); end
    n_checks++; if (bus.CKSUM !== 8'h00) begin n_fail++; $display("FAIL reset_cksum got %h want 00", bus.CKSUM); end
    n_checks++; if (bus.BYTE_COUNT !== 13'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.BYTE_COUNT); end
    n_checks++; if (bus.DB !== 8'hFF) begin n_fail++; $display("FAIL reset_db got %h want FF", bus.DB); end
    res = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    int rise;
    logic [7:0] d;
    start_dl();
    for (int i = 0; i < 256; i++) wr_byte(12'(i), 8'(i));
    n_checks++; if (bus.BYTE_COUNT !== exp_count()) begin n_fail++; $display("FAIL full_count got %0d want %0d", bus.BYTE_COUNT, exp_count()); end
    n_checks++; if (bus.CKSUM !== exp_cksum()) begin n_fail++; $display("FAIL full_cksum got %h want %h", bus.CKSUM, exp_cksum()); end
    release_wait(1'b0, 12'h0, 8'h0, rise);
    n_checks++; if (rise !== 17) begin n_fail++; $display("FAIL full_release_cycle got %0d want 17", rise); end
    n_checks++; if (bus.LOADED !== 1'b1) begin n_fail++; $display("FAIL full_loaded got %b want 1", bus.LOADED); end
    n_checks++; if (bus.CKSUM !== exp_cksum()) begin n_fail++; $display("FAIL full_cksum_hold got %h want %h", bus.CKSUM, exp_cksum()); end
    read_db(16'h0010, d);
    n_checks++; if (d !== exp_db(16'h0010)) begin n_fail++; $display("FAIL full_read10 got %h want %h", d, exp_db(16'h0010)); end
  endtask

  task automatic test_random_load();
    int rise;
    int n;
    logic [7:0] d;
    logic [15:0] a;
    start_dl();
    n_checks++; if ({bus.CPU_RESETB, bus.LOADED} !== 2'b00) begin n_fail++; $display("FAIL rnd_entry_release got %b want 00", {bus.CPU_RESETB, bus.LOADED}); end
    n_checks++; if ({bus.CKSUM, bus.BYTE_COUNT} !== 21'd0) begin n_fail++; $display("FAIL rnd_entry_clear got %h/%0d want 0/0", bus.CKSUM, bus.BYTE_COUNT); end
    n = $urandom_range(20, 60);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      wr_byte(12'($urandom_range(0, 15)), 8'($urandom));
    end
    wr_byte(12'hFFF, 8'($urandom));
    n_checks++; if (bus.BYTE_COUNT !== exp_count()) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", bus.BYTE_COUNT, exp_count()); end
    n_checks++; if (bus.CKSUM !== exp_cksum()) begin n_fail++; $display("FAIL rnd_cksum got %h want %h", bus.CKSUM, exp_cksum()); end
    release_wait(1'b1, 12'h003, ~ref_mem[3], rise);
    n_checks++; if (rise !== 17) begin n_fail++; $display("FAIL rnd_release_cycle got %0d want 17", rise); end
    n_checks++; if (bus.BYTE_COUNT !== exp_count()) begin n_fail++; $display("FAIL rnd_count_after_fall got %0d want %0d", bus.BYTE_COUNT, exp_count()); end
    n_checks++; if (bus.CKSUM !== exp_cksum()) begin n_fail++; $display("FAIL rnd_cksum_after_fall got %h want %h", bus.CKSUM, exp_cksum()); end
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) a = {4'h0, 12'($urandom_range(0, 255))};
      else a = {4'($urandom_range(1, 15)), 12'($urandom)};
      read_db(a, d);
      n_checks++; if (d !== exp_db(a)) begin n_fail++; $display("FAIL rnd_read addr %h got %h want %h", a, d, exp_db(a)); end
    end
  endtask

  task automatic test_decode();
    logic [7:0] d;
    bus.A = 16'h1000;
    #1;
    n_checks++; if (bus.nCS !== 1'b1) begin n_fail++; $display("FAIL dec_ncs_1000 got %b want 1", bus.nCS); end
    step();
    n_checks++; if (bus.DB !== 8'hFF) begin n_fail++; $display("FAIL dec_db_1000 got %h want FF", bus.DB); end
    bus.A = 16'h0FFF;
    #1;
    n_checks++; if (bus.nCS !== 1'b0) begin n_fail++; $display("FAIL dec_ncs_0fff got %b want 0", bus.nCS); end
    step();
    n_checks++; if (bus.DB !== exp_db(16'h0FFF)) begin n_fail++; $display("FAIL dec_db_0fff got %h want %h", bus.DB, exp_db(16'h0FFF)); end
    bus.DL_WR = 1'b1;
    bus.DL_ADDR = 12'hFFF;
    bus.DL_DATA = ~ref_mem[12'hFFF];
    step();
    bus.DL_WR = 1'b0;
    read_db(16'h0FFF, d);
    n_checks++; if (d !== exp_db(16'h0FFF)) begin n_fail++; $display("FAIL dec_stray_write got %h want %h", d, exp_db(16'h0FFF)); end
    n_checks++; if (bus.BYTE_COUNT !== exp_count()) begin n_fail++; $display("FAIL dec_stray_count got %0d want %0d", bus.BYTE_COUNT, exp_count()); end
  endtask

  task automatic test_empty();
    bit seen_high;
    logic [7:0] d;
    bus.DL_ACTIVE = 1'b1;
    repeat (5) step();
    bus.DL_ACTIVE = 1'b0;
    ref_sum = 0;
    ref_n = 0;
    seen_high = 1'b0;
    repeat (30) begin
      step();
      if (bus.CPU_RESETB !== 1'b0 || bus.LOADED !== 1'b0) seen_high = 1'b1;
    end
    n_checks++; if (seen_high !== 1'b0) begin n_fail++; $display("FAIL empty_release got %b want 0", seen_high); end
    n_checks++; if (bus.BYTE_COUNT !== exp_count()) begin n_fail++; $display("FAIL empty_count got %0d want %0d", bus.BYTE_COUNT, exp_count()); end
    read_db(16'h0010, d);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL empty_db got %h want FF", d); end
  endtask

  task automatic test_reload();
    int rise;
    logic [7:0] d;
    start_dl();
    wr_byte(12'h001, 8'($urandom));
    release_wait(1'b0, 12'h0, 8'h0, rise);
    n_checks++; if (rise !== 17) begin n_fail++; $display("FAIL reload_first_release got %0d want 17", rise); end
    start_dl();
    n_checks++; if ({bus.CPU_RESETB, bus.LOADED} !== 2'b00) begin n_fail++; $display("FAIL reload_drop got %b want 00", {bus.CPU_RESETB, bus.LOADED}); end
    n_checks++; if ({bus.CKSUM, bus.BYTE_COUNT} !== 21'd0) begin n_fail++; $display("FAIL reload_clear got %h/%0d want 0/0", bus.CKSUM, bus.BYTE_COUNT); end
    wr_byte(12'h000, 8'hA5);
    release_wait(1'b0, 12'h0, 8'h0, rise);
    n_checks++; if (rise !== 17) begin n_fail++; $display("FAIL reload_release got %0d want 17", rise); end
    read_db(16'h0000, d);
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL reload_db got %h want A5", d); end
  endtask

  task automatic test_reset_mid();
    int rise;
    bit seen_high;
    logic [7:0] d;
    start_dl();
    for (int i = 0; i < 3; i++) wr_byte(12'h020 + 12'(i), 8'($urandom));
    n_checks++; if (bus.BYTE_COUNT !== exp_count()) begin n_fail++; $display("FAIL rmid_count3 got %0d want %0d", bus.BYTE_COUNT, exp_count()); end
    res = 1'b1;
    step();
    res = 1'b0;
    ref_sum = 0;
    ref_n = 0;
    n_checks++; if ({bus.CPU_RESETB, bus.LOADED, bus.CKSUM, bus.BYTE_COUNT, bus.DB} !== {2'b00, 8'h00, 13'd0, 8'hFF}) begin
      n_fail++; $display("FAIL rmid_load_reset got %b%b %h %0d %h want 00 00 0 FF", bus.CPU_RESETB, bus.LOADED, bus.CKSUM, bus.BYTE_COUNT, bus.DB);
    end
    bus.DL_WR = 1'b1;
    bus.DL_ADDR = 12'hFFF;
    bus.DL_DATA = ~ref_mem[12'hFFF];
    step();
    bus.DL_WR = 1'b0;
    n_checks++; if ({bus.CKSUM, bus.BYTE_COUNT} !== 21'd0) begin n_fail++; $display("FAIL rmid_idle_write got %h/%0d want 0/0", bus.CKSUM, bus.BYTE_COUNT); end
    wr_byte(12'h100, 8'($urandom));
    n_checks++; if (bus.BYTE_COUNT !== exp_count()) begin n_fail++; $display("FAIL rmid_count1 got %0d want %0d", bus.BYTE_COUNT, exp_count()); end
    bus.DL_ACTIVE = 1'b0;
    repeat (5) step();
    res = 1'b1;
    step();
    res = 1'b0;
    ref_sum = 0;
    ref_n = 0;
    n_checks++; if ({bus.CPU_RESETB, bus.LOADED, bus.CKSUM, bus.BYTE_COUNT, bus.DB} !== {2'b00, 8'h00, 13'd0, 8'hFF}) begin
      n_fail++; $display("FAIL rmid_settle_reset got %b%b %h %0d %h want 00 00 0 FF", bus.CPU_RESETB, bus.LOADED, bus.CKSUM, bus.BYTE_COUNT, bus.DB);
    end
    seen_high = 1'b0;
    repeat (30) begin
      step();
      if (bus.CPU_RESETB !== 1'b0) seen_high = 1'b1;
    end
    n_checks++; if (seen_high !== 1'b0) begin n_fail++; $display("FAIL rmid_no_release got %b want 0", seen_high); end
    start_dl();
    wr_byte(12'h101, 8'($urandom));
    release_wait(1'b0, 12'h0, 8'h0, rise);
    n_checks++; if (rise !== 17) begin n_fail++; $display("FAIL rmid_release got %0d want 17", rise); end
    read_db(16'h0FFF, d);
    n_checks++; if (d !== exp_db(16'h0FFF)) begin n_fail++; $display("FAIL rmid_keep_fff got %h want %h", d, exp_db(16'h0FFF)); end
    read_db(16'h0021, d);
    n_checks++; if (d !== exp_db(16'h0021)) begin n_fail++; $display("FAIL rmid_keep_021 got %h want %h", d, exp_db(16'h0021)); end
  endtask

  task automatic test_saturation();
    int rise;
    logic [7:0] d;
    logic [15:0] a;
    start_dl();
    for (int i = 0; i < 4100; i++) wr_byte(12'(i), 8'($urandom));
    n_checks++; if (bus.BYTE_COUNT !== exp_count()) begin n_fail++; $display("FAIL sat_count got %0d want %0d", bus.BYTE_COUNT, exp_count()); end
    n_checks++; if (bus.CKSUM !== exp_cksum()) begin n_fail++; $display("FAIL sat_cksum got %h want %h", bus.CKSUM, exp_cksum()); end
    release_wait(1'b0, 12'h0, 8'h0, rise);
    n_checks++; if (rise !== 17) begin n_fail++; $display("FAIL sat_release got %0d want 17", rise); end
    for (int i = 0; i < 16; i++) begin
      a = (i < 4) ? 16'(i) : {4'h0, 12'($urandom)};
      read_db(a, d);
      n_checks++; if (d !== exp_db(a)) begin n_fail++; $display("FAIL sat_read addr %h got %h want %h", a, d, exp_db(a)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_random_load();
    test_decode();
    test_empty();
    test_reload();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bootrom_loader.md
BOOTROM_LOADER -- requirements
Module: bootrom_loader

Interface
REQ-001 SHALL have parameter RELEASE_CYCLES, default 16, giving the number of CLK cycles CPU reset is held after a download ends (range 1..255).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RES  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port DL_ACTIVE  input  1  download window; high while the host streams ROM bytes.
REQ-005 SHALL have port DL_WR  input  1  single-cycle write strobe, valid only while DL_ACTIVE=1.
REQ-006 SHALL have port DL_ADDR  input  12  byte address of the download write.
REQ-007 SHALL have port DL_DATA  input  8  byte to write.
REQ-008 SHALL have port A  input  16  CPU address bus from upd7800.
REQ-009 SHALL have port DB  output  8  read data to the CPU DB_I.
REQ-010 SHALL have port nCS  output  1  ROM select, low when A[15:12]=0.
REQ-011 SHALL have port CPU_RESETB  output  1  active-low reset driven to upd7800 RESETB.
REQ-012 SHALL have port LOADED  output  1  high while the ROM holds a completed image and the CPU runs.
REQ-013 SHALL have port CKSUM  output  8  modulo-256 sum of all bytes written in the current download.
REQ-014 SHALL have port BYTE_COUNT  output  13  number of accepted writes in the current download, saturating at 4096.

Function
REQ-015 SHALL contain a 4096x8 memory written only from the download port.
REQ-016 SHALL implement states IDLE, LOAD, SETTLE, RUN; encoding free.
REQ-017 SHALL move IDLE->LOAD, and RUN->LOAD, on the first cycle DL_ACTIVE=1; on entry it clears CKSUM and BYTE_COUNT and drops LOADED and CPU_RESETB the next cycle.
REQ-018 SHALL, in LOAD, on each cycle with DL_WR=1: write DL_DATA to mem[DL_ADDR], add DL_DATA to CKSUM with wrap at 256, and increment BYTE_COUNT, stopping at 4096.
REQ-019 SHALL ignore DL_WR whenever DL_ACTIVE=0 or state is not LOAD.
REQ-020 SHALL, when DL_ACTIVE falls in LOAD, go to SETTLE if BYTE_COUNT>0, else go to IDLE.
REQ-021 SHALL, if DL_WR=1 in the cycle DL_ACTIVE falls, ignore that write.
REQ-022 SHALL, in SETTLE, count RELEASE_CYCLES cycles, then enter RUN; if DL_ACTIVE rises during SETTLE, return to LOAD per REQ-017.
REQ-023 SHALL drive CPU_RESETB=1 and LOADED=1 only in RUN, registered, so both rise together RELEASE_CYCLES+1 cycles after DL_ACTIVE falls.
REQ-024 SHALL drive nCS combinationally as the OR of A[15:12].
REQ-025 SHALL register DB with 1-cycle latency: DB = mem[A[11:0]] when state is RUN and nCS was 0 in the sampled cycle, else 8'hFF.
REQ-026 SHALL hold CKSUM and BYTE_COUNT stable outside LOAD.
REQ-027 SHALL tolerate rewrites of the same address; the last byte wins, and CKSUM and BYTE_COUNT still count every write.

Reset
REQ-028 SHALL, on RES=1 at a CLK edge, enter IDLE with CPU_RESETB=0, LOADED=0, CKSUM=0, BYTE_COUNT=0, DB=8'hFF, and the SETTLE counter at 0.
REQ-029 SHALL not clear memory contents on RES; a new download is nonetheless required to reach RUN.
REQ-030 SHALL give RES priority over all other inputs, including mid-LOAD and mid-SETTLE.

Verification
REQ-031 SHALL cover a full load: write bytes 0x00..0xFF to addresses 0..255, then drop DL_ACTIVE -> BYTE_COUNT=256, CKSUM=0x80, CPU_RESETB and LOADED rise exactly 17 cycles after the fall, and A=0x0010 returns DB=0x10 one cycle later.
REQ-032 SHALL cover decode: in RUN, A=0x1000 -> nCS=1 and DB=0xFF the next cycle; A=0x0FFF -> nCS=0 and DB=mem[0xFFF].
REQ-033 SHALL cover an empty download: pulse DL_ACTIVE for 5 cycles with no DL_WR -> returns to IDLE, CPU_RESETB remains 0, LOADED=0.
REQ-034 SHALL cover a reload while running: raise DL_ACTIVE in RUN -> CPU_RESETB=0 and LOADED=0 the next cycle, CKSUM=0, BYTE_COUNT=0; write 0xA5 to 0x000 -> after release, DB=0xA5 for A=0.
REQ-035 SHALL cover reset mid-operation: assert RES in LOAD after 3 writes, and again in SETTLE -> IDLE, all outputs at their reset values, and DL_WR ignored until DL_ACTIVE is seen high in IDLE.
REQ-036 SHALL cover saturation: 4100 writes -> BYTE_COUNT=4096, and CKSUM equals the modulo-256 sum of all 4100 bytes.
